decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//  RV32I decode stage; sits between the fetch stage's IF/ID register and the execute stage.
//  Holds the 32x32 register file: written from writeback, read here.
//  Decodes InstrD into control fields and the sign-extended immediate.
//  Registers everything into the ID/EX pipeline register, with synchronous flush for hazard/branch recovery.
// PARAMETERS
//  XLEN     32  data/address width
//  REG_AW   5   register index width (2**REG_AW registers)
// PORTS
//  clk          in   1     clock; all state updates on posedge
//  rst          in   1     asynchronous, active-low reset
//  InstrD       in   32    instruction from IF/ID
//  PCD          in   32    PC of InstrD
//  PCPlus4D     in   32    PCD+4
//  RegWriteW    in   1     writeback register-write enable
//  RdW          in   5     writeback destination index
//  ResultW      in   32    writeback data
//  FlushE       in   1     synchronous clear of ID/EX (insert bubble)
//  Rs1D,Rs2D    out  5     combinational source indices, for hazard unit
//  RegWriteE    out  1     ID/EX control outputs:
//  ResultSrcE   out  2       00 ALU, 01 memory, 10 PC+4
//  MemWriteE    out  1
//  JumpE        out  1
//  BranchE      out  1
//  ALUControlE  out  3       000 add, 001 sub, 010 and, 011 or, 101 slt
//  ALUSrcE      out  1       0 = RD2, 1 = immediate
//  RD1E,RD2E    out  32    registered operands
//  ImmExtE      out  32    registered sign-extended immediate
//  Rs1E,Rs2E,RdE out 5     registered register indices
//  PCE,PCPlus4E out  32    registered PC / PC+4
// BEHAVIOUR
//  - Reset (rst=0, async):
//    - every ID/EX output = 0
//    - all 32 registers = 0
//  - Latency: one cycle. Outputs E reflect the D inputs sampled at the previous posedge.
//  - Priority per posedge: rst > FlushE > normal capture.
//    - FlushE=1 clears every ID/EX field to 0: a NOP bubble with RegWriteE=MemWriteE=JumpE=BranchE=0.
//    - FlushE does not block a register-file write in the same cycle.
//  - Register file:
//    - Write at posedge when RegWriteW=1 and RdW!=0.
//    - x0 always reads 0; writes to x0 are ignored.
//  - Decode supports these opcodes:
//    - R 0110011: add, sub, and, or, slt
//    - I-ALU 0010011: addi, andi, ori, slti
//    - lw 0000011, sw 0100011, beq 1100011, jal 1101111
//  - R-type: funct7[5]=1 with funct3=000 selects sub.
//    - On I-type, funct7 is ignored (addi is never decoded as sub).
//  - Immediates:
//    - I = {20{i[31]},i[31:20]}
//    - S = {20{i[31]},i[31:25],i[11:7]}
//    - B = {19{i[31]},i[31],i[7],i[30:25],i[11:8],0}
//    - J = {11{i[31]},i[31],i[19:12],i[20],i[30:21],0}
//  - Unsupported opcode or funct: all control = 0 (behaves as a bubble); ImmExt = 0.
//  - InstrD = 0 (the post-reset/flush fetch value) decodes as a bubble.
//  - beq/jal ALUControl = 001 (sub) and 000 respectively; target computation lives in execute.
// CONFIGURATION
//  REGFILE_BYPASS_EN
//   - Defined: a read of register r in the same cycle that writeback writes r (r != 0) returns ResultW (write-through).
//   - Undefined: the read returns the old register contents, and the hazard unit must stall one extra cycle.
// STRUCTURE
//  - Shared package/header holds:
//    - opcode constants (OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL)
//    - ALUControl encodings
//    - ResultSrc encodings
//  - One sub-module: reg_file.
//    - Two async read ports, one sync write port, x0 hardwired.
//    - Contains the bypass logic.
//  - Control decode and immediate extension stay in this module as combinational blocks.
// TESTING
//  1 Reset mid-run: rst low -> all E outputs 0 asynchronously, before any clk edge; then read x5 -> 0.
//  2 Writeback then read:
//    - Write x5=0x1234 (RegWriteW=1); next cycle InstrD=add x6,x5,x5 (0x00528333).
//    - Expect RD1E=RD2E=0x1234, RegWriteE=1, ALUControlE=000, ALUSrcE=0.
//    - Attempt a write to x0 -> x0 still reads 0.
//  3 Immediates:
//    - lw x1,-4(x2) = 0xFFC12083 -> ImmExtE=0xFFFFFFFC, ResultSrcE=01, ALUSrcE=1.
//    - sw x1,8(x2) = 0x00112423 -> ImmExtE=8, MemWriteE=1, RegWriteE=0.
//  4 Branch/jump:
//    - beq x1,x2,-8 = 0xFE208CE3 -> ImmExtE=0xFFFFFFF8, BranchE=1, ALUControlE=001.
//    - jal x1,16 = 0x010000EF -> JumpE=1, ResultSrcE=10, ImmExtE=16.
//  5 Flush: FlushE=1 with a valid add in D -> next cycle all E outputs 0; register-file write in the same cycle still lands.
//  6 Bypass:
//    - Same-cycle write x7=0xA5 and read of x7.
//    - With REGFILE_BYPASS_EN: RD1E=0xA5.
//    - Without it: RD1E=old value (0).

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode constants, control/pipeline payload types and the funct3 ALU helper.
package decode_stage_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned NREGS  = 2 ** REG_AW;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   typedef struct packed {
      logic       regWrite;
      logic [1:0] resultSrc;
      logic       memWrite;
      logic       jump;
      logic       branch;
      logic [2:0] aluControl;
      logic       aluSrc;
   } ctrlT;

   typedef struct packed {
      ctrlT              ctrl;
      logic [XLEN-1:0]   rd1;
      logic [XLEN-1:0]   rd2;
      logic [XLEN-1:0]   immExt;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   pcPlus4;
   } idExT;

   // {valid, aluControl} for the funct3 values shared by R-type and I-ALU
   function automatic logic [3:0] aluOp(input logic [2:0] funct3);
      case (funct3)
         3'b000:  aluOp = {1'b1, ALU_ADD};
         3'b111:  aluOp = {1'b1, ALU_AND};
         3'b110:  aluOp = {1'b1, ALU_OR};
         3'b010:  aluOp = {1'b1, ALU_SLT};
         default: aluOp = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// 32-entry register file: two async read ports, one sync write port, x0 hardwired to zero.
// REGFILE_BYPASS_EN: when defined, a same-cycle write to the read index is forwarded to the read port.
module decode_stage_reg_file
   import decode_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] ra1,
   input  logic [REG_AW-1:0] ra2,
   input  logic              we,
   input  logic [REG_AW-1:0] wa,
   input  logic [XLEN-1:0]   wd,
   output logic [XLEN-1:0]   rd1C,
   output logic [XLEN-1:0]   rd2C
);

   logic [XLEN-1:0] regs [NREGS];
   logic            hit1;
   logic            hit2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

`ifdef REGFILE_BYPASS_EN
   assign hit1 = we && (wa == ra1);
   assign hit2 = we && (wa == ra2);
`else
   assign hit1 = 1'b0;
   assign hit2 = 1'b0;
`endif

   // x0 gate comes first so a bypassed write to x0 can never leak through
   assign rd1C = (ra1 == '0) ? '0 : (hit1 ? wd : regs[ra1]);
   assign rd2C = (ra2 == '0) ? '0 : (hit2 ? wd : regs[ra2]);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register file read, control/immediate decode and the ID/EX pipeline register.
// Optional REGFILE_BYPASS_EN enables write-through reads in the register file.
module decode_stage
   import decode_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [XLEN-1:0]   InstrD,
   input  logic [XLEN-1:0]   PCD,
   input  logic [XLEN-1:0]   PCPlus4D,
   input  logic              RegWriteW,
   input  logic [REG_AW-1:0] RdW,
   input  logic [XLEN-1:0]   ResultW,
   input  logic              FlushE,
   output logic [REG_AW-1:0] Rs1D,
   output logic [REG_AW-1:0] Rs2D,
   output logic              RegWriteE,
   output logic [1:0]        ResultSrcE,
   output logic              MemWriteE,
   output logic              JumpE,
   output logic              BranchE,
   output logic [2:0]        ALUControlE,
   output logic              ALUSrcE,
   output logic [XLEN-1:0]   RD1E,
   output logic [XLEN-1:0]   RD2E,
   output logic [XLEN-1:0]   ImmExtE,
   output logic [REG_AW-1:0] Rs1E,
   output logic [REG_AW-1:0] Rs2E,
   output logic [REG_AW-1:0] RdE,
   output logic [XLEN-1:0]   PCE,
   output logic [XLEN-1:0]   PCPlus4E
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [3:0]      aluDec;
   logic [XLEN-1:0] immI, immS, immB, immJ;
   logic [XLEN-1:0] rd1D, rd2D;
   ctrlT            ctrlD;
   logic [XLEN-1:0] immExtD;
   idExT            idExQ;

   assign opcode = InstrD[6:0];
   assign funct3 = InstrD[14:12];
   assign funct7 = InstrD[31:25];
   assign Rs1D   = InstrD[19:15];
   assign Rs2D   = InstrD[24:20];
   assign aluDec = aluOp(funct3);

   assign immI = {{20{InstrD[31]}}, InstrD[31:20]};
   assign immS = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
   assign immB = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
   assign immJ = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};

   decode_stage_reg_file u_regFile (
      .clk  (clk),
      .rst  (rst),
      .ra1  (Rs1D),
      .ra2  (Rs2D),
      .we   (RegWriteW),
      .wa   (RdW),
      .wd   (ResultW),
      .rd1C (rd1D),
      .rd2C (rd2D)
   );

   // Control/immediate decode; anything not recognised stays an all-zero bubble
   always_comb begin
      ctrlD   = '0;
      immExtD = '0;
      case (opcode)
         OP_R: begin
            if ((funct7 == 7'b0100000) && (funct3 == 3'b000)) begin
               ctrlD.regWrite   = 1'b1;
               ctrlD.aluControl = ALU_SUB;
            end else if ((funct7 == 7'b0000000) && aluDec[3]) begin
               ctrlD.regWrite   = 1'b1;
               ctrlD.resultSrc  = RES_ALU;
               ctrlD.aluControl = aluDec[2:0];
            end
         end
         OP_I: begin
            if (aluDec[3]) begin
               ctrlD.regWrite   = 1'b1;
               ctrlD.aluSrc     = 1'b1;
               ctrlD.aluControl = aluDec[2:0];
               immExtD          = immI;
            end
         end
         OP_LW: begin
            if (funct3 == 3'b010) begin
               ctrlD.regWrite   = 1'b1;
               ctrlD.resultSrc  = RES_MEM;
               ctrlD.aluSrc     = 1'b1;
               ctrlD.aluControl = ALU_ADD;
               immExtD          = immI;
            end
         end
         OP_SW: begin
            if (funct3 == 3'b010) begin
               ctrlD.memWrite   = 1'b1;
               ctrlD.aluSrc     = 1'b1;
               ctrlD.aluControl = ALU_ADD;
               immExtD          = immS;
            end
         end
         OP_BEQ: begin
            if (funct3 == 3'b000) begin
               ctrlD.branch     = 1'b1;
               ctrlD.aluControl = ALU_SUB;
               immExtD          = immB;
            end
         end
         OP_JAL: begin
            ctrlD.regWrite   = 1'b1;
            ctrlD.jump       = 1'b1;
            ctrlD.resultSrc  = RES_PC4;
            ctrlD.aluControl = ALU_ADD;
            immExtD          = immJ;
         end
         default: ;
      endcase
   end

   // ID/EX register; flush inserts a full-zero bubble but leaves the regfile write alone
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idExQ <= '0;
      end else if (FlushE) begin
         idExQ <= '0;
      end else begin
         idExQ.ctrl    <= ctrlD;
         idExQ.rd1     <= rd1D;
         idExQ.rd2     <= rd2D;
         idExQ.immExt  <= immExtD;
         idExQ.rs1     <= Rs1D;
         idExQ.rs2     <= Rs2D;
         idExQ.rd      <= InstrD[11:7];
         idExQ.pc      <= PCD;
         idExQ.pcPlus4 <= PCPlus4D;
      end
   end

   assign RegWriteE   = idExQ.ctrl.regWrite;
   assign ResultSrcE  = idExQ.ctrl.resultSrc;
   assign MemWriteE   = idExQ.ctrl.memWrite;
   assign JumpE       = idExQ.ctrl.jump;
   assign BranchE     = idExQ.ctrl.branch;
   assign ALUControlE = idExQ.ctrl.aluControl;
   assign ALUSrcE     = idExQ.ctrl.aluSrc;
   assign RD1E        = idExQ.rd1;
   assign RD2E        = idExQ.rd2;
   assign ImmExtE     = idExQ.immExt;
   assign Rs1E        = idExQ.rs1;
   assign Rs2E        = idExQ.rs2;
   assign RdE         = idExQ.rd;
   assign PCE         = idExQ.pc;
   assign PCPlus4E    = idExQ.pcPlus4;

endmodule
